sample_dma: RTL and testbench

Parametrised multi-channel DMA engine that moves sample words from CHANNELS independent sample FIFOs (clk_48 read side) into SDRAM through the sdram write handshake (awaddr/wdata/wvalid/wready). It generalises the single-channel CPU-driven SDRAM write path. Each channel has its own base, size and write pointer. Each channel runs in linear (stop-when-full) or circular (ring) mode. Channels are programmed over the CPU IO bus.

---
 rtl/sample_dma.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_sample_dma.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_dma.sv
// sample_dma: round-robin DMA from CHANNELS sample FIFOs into SDRAM writes.
// Optional irq output and CTRL bits 2/10 when SAMPLE_DMA_IRQ_EN is defined.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   fifo_empty/data/rd       per-channel FIFO read side (1-cycle read latency)
//   awaddr/wdata/wvalid      SDRAM write request, held until wready
//   wready                   SDRAM write accept
//   ctrl_addr/wr_data/strobe CPU register write, addr = {chan[3:0], reg[1:0]}
//   ctrl_rd_data             combinational register read
//   busy                     high from FIFO read until the write is accepted
//   irq                      (SAMPLE_DMA_IRQ_EN only) registered interrupt
module sample_dma #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        fifo_empty,
    input  logic [CHANNELS*DATA_W-1:0] fifo_data,
    output logic [CHANNELS-1:0]        fifo_rd,
    output logic [ADDR_W-1:0]          awaddr,
    output logic [DATA_W-1:0]          wdata,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [5:0]                 ctrl_addr,
    input  logic [31:0]                ctrl_wr_data,
    input  logic                       ctrl_wr_strobe,
    output logic [31:0]                ctrl_rd_data,
`ifdef SAMPLE_DMA_IRQ_EN
    output logic                       irq,
`endif
    output logic                       busy
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_LAT, S_WR} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [CW-1:0]         rr_q, rr_d;
    logic [CHANNELS-1:0]   fifo_rd_q, fifo_rd_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  wvalid_q, wvalid_d;
    logic                  busy_q, busy_d;

    logic [CHANNELS-1:0]   en_q, en_d;
    logic [CHANNELS-1:0]   circ_q, circ_d;
    logic [CHANNELS-1:0]   full_q, full_d;
    logic [CHANNELS-1:0]   wrap_q, wrap_d;
    logic [ADDR_W-1:0]     base_q [CHANNELS];
    logic [ADDR_W-1:0]     base_d [CHANNELS];
    logic [ADDR_W-1:0]     size_q [CHANNELS];
    logic [ADDR_W-1:0]     size_d [CHANNELS];
    logic [ADDR_W-1:0]     wptr_q [CHANNELS];
    logic [ADDR_W-1:0]     wptr_d [CHANNELS];
`ifdef SAMPLE_DMA_IRQ_EN
    logic [CHANNELS-1:0]   irq_en_q, irq_en_d;
    logic [CHANNELS-1:0]   half_q, half_d;
    logic                  irq_q, irq_d;
`endif

    logic [CHANNELS-1:0]   elig;
    logic                  found;
    logic [CW-1:0]         sel;
    logic                  accept;
    logic [DATA_W-1:0]     cur_data;
    logic [ADDR_W-1:0]     cur_base;
    logic [ADDR_W-1:0]     cur_wptr;
    int                    ctrl_ch;
    logic [1:0]            ctrl_reg;
    logic                  unused_wr_data;

    assign ctrl_ch        = int'(ctrl_addr[5:2]);
    assign ctrl_reg       = ctrl_addr[1:0];
    assign unused_wr_data = ^ctrl_wr_data;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            elig[i] = en_q[i] && !fifo_empty[i] &&
                      (size_q[i] != '0) && !full_q[i];
        end
    end

    // Round-robin search starting at rr_q (one past the last served channel).
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && elig[(int'(rr_q) + k) % CHANNELS]) begin
                found = 1'b1;
                sel   = CW'((int'(rr_q) + k) % CHANNELS);
            end
        end
    end

    always_comb begin
        cur_data = '0;
        cur_base = '0;
        cur_wptr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == CW'(i)) begin
                cur_data = fifo_data[i*DATA_W +: DATA_W];
                cur_base = base_q[i];
                cur_wptr = wptr_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        fifo_rd_d = '0;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wvalid_d  = wvalid_q;
        busy_d    = busy_q;
        en_d      = en_q;
        circ_d    = circ_q;
        full_d    = full_q;
        wrap_d    = wrap_q;
        base_d    = base_q;
        size_d    = size_q;
        wptr_d    = wptr_q;
        accept    = 1'b0;
`ifdef SAMPLE_DMA_IRQ_EN
        irq_en_d  = irq_en_q;
        half_d    = half_q;
        irq_d     = |(irq_en_q & (half_q | wrap_q | full_q));
`endif

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_RD;
                    ch_d    = sel;
                    busy_d  = 1'b1;
                    for (int i = 0; i < CHANNELS; i++) begin
                        fifo_rd_d[i] = (sel == CW'(i));
                    end
                end
            end
            S_RD: begin
                state_d = S_LAT;
            end
            S_LAT: begin
                wdata_d  = cur_data;
                awaddr_d = cur_base + cur_wptr;
                wvalid_d = 1'b1;
                state_d  = S_WR;
            end
            S_WR: begin
                if (wready) begin
                    wvalid_d = 1'b0;
                    busy_d   = 1'b0;
                    accept   = 1'b1;
                    state_d  = S_IDLE;
                    rr_d     = (ch_q == CW'(CHANNELS - 1)) ? '0
                                                          : ch_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < CHANNELS; i++) begin
            if (accept && ch_q == CW'(i)) begin
                if (({1'b0, wptr_q[i]} + 1'b1) < {1'b0, size_q[i]}) begin
                    wptr_d[i] = wptr_q[i] + 1'b1;
`ifdef SAMPLE_DMA_IRQ_EN
                    if ((wptr_q[i] + 1'b1) == (size_q[i] >> 1)) begin
                        half_d[i] = 1'b1;
                    end
`endif
                end else if (circ_q[i]) begin
                    wptr_d[i] = '0;
                    wrap_d[i] = 1'b1;
`ifdef SAMPLE_DMA_IRQ_EN
                    half_d[i] = 1'b1;
`endif
                end else begin
                    // SIZE may have been rewritten to 0 mid-transfer.
                    full_d[i] = 1'b1;
                    wptr_d[i] = (size_q[i] != '0) ? size_q[i] - 1'b1 : '0;
`ifdef SAMPLE_DMA_IRQ_EN
                    half_d[i] = 1'b1;
`endif
                end
            end

            // CPU writes are applied last so they override the pointer update.
            if (ctrl_wr_strobe && ctrl_ch == i) begin
                unique case (ctrl_reg)
                    2'd0: begin
                        en_d[i]   = ctrl_wr_data[0];
                        circ_d[i] = ctrl_wr_data[1];
                        if (ctrl_wr_data[9]) begin
                            wrap_d[i] = 1'b0;
                        end
`ifdef SAMPLE_DMA_IRQ_EN
                        irq_en_d[i] = ctrl_wr_data[2];
                        if (ctrl_wr_data[10]) begin
                            half_d[i] = 1'b0;
                        end
`endif
                    end
                    2'd1: base_d[i] = ctrl_wr_data[ADDR_W-1:0];
                    2'd2: size_d[i] = ctrl_wr_data[ADDR_W-1:0];
                    2'd3: begin
                        wptr_d[i] = '0;
                        full_d[i] = 1'b0;
                        wrap_d[i] = wrap_q[i];
`ifdef SAMPLE_DMA_IRQ_EN
                        half_d[i] = half_q[i];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ctrl_rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ctrl_ch == i) begin
                unique case (ctrl_reg)
                    2'd0: begin
                        ctrl_rd_data[0] = en_q[i];
                        ctrl_rd_data[1] = circ_q[i];
                        ctrl_rd_data[8] = full_q[i];
                        ctrl_rd_data[9] = wrap_q[i];
`ifdef SAMPLE_DMA_IRQ_EN
                        ctrl_rd_data[2]  = irq_en_q[i];
                        ctrl_rd_data[10] = half_q[i];
`endif
                    end
                    2'd1: ctrl_rd_data[ADDR_W-1:0] = base_q[i];
                    2'd2: ctrl_rd_data[ADDR_W-1:0] = size_q[i];
                    2'd3: ctrl_rd_data[ADDR_W-1:0] = wptr_q[i];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            rr_q      <= '0;
            fifo_rd_q <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= '0;
            circ_q    <= '0;
            full_q    <= '0;
            wrap_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                base_q[i] <= '0;
                size_q[i] <= '0;
                wptr_q[i] <= '0;
            end
`ifdef SAMPLE_DMA_IRQ_EN
            irq_en_q  <= '0;
            half_q    <= '0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_q      <= rr_d;
            fifo_rd_q <= fifo_rd_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
            circ_q    <= circ_d;
            full_q    <= full_d;
            wrap_q    <= wrap_d;
            for (int i = 0; i < CHANNELS; i++) begin
                base_q[i] <= base_d[i];
                size_q[i] <= size_d[i];
                wptr_q[i] <= wptr_d[i];
            end
`ifdef SAMPLE_DMA_IRQ_EN
            irq_en_q  <= irq_en_d;
            half_q    <= half_d;
            irq_q     <= irq_d;
`endif
        end
    end

    assign fifo_rd = fifo_rd_q;
    assign awaddr  = awaddr_q;
    assign wdata   = wdata_q;
    assign wvalid  = wvalid_q;
    assign busy    = busy_q;
`ifdef SAMPLE_DMA_IRQ_EN
    assign irq     = irq_q;
`endif

endmodule

// File: tb/tb_sample_dma.sv
// Scoreboard bench for sample_dma: FIFO model, write monitor, scenario tasks.
// Expected SDRAM writes are queued when stimulus is driven.
module tb_sample_dma;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int AW = 24;
`ifdef SAMPLE_DMA_IRQ_EN
    localparam logic [31:0] HALF  = 32'h400;
    localparam logic [31:0] IRQEN = 32'h4;
`else
    localparam logic [31:0] HALF  = 32'h0;
    localparam logic [31:0] IRQEN = 32'h0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CH-1:0]     fifo_empty;
    logic [CH*DW-1:0]  fifo_data;
    logic [CH-1:0]     fifo_rd;
    logic [AW-1:0]     awaddr;
    logic [DW-1:0]     wdata;
    logic              wvalid;
    logic              wready;
    logic [5:0]        ctrl_addr;
    logic [31:0]       ctrl_wr_data;
    logic              ctrl_wr_strobe;
    logic [31:0]       ctrl_rd_data;
    logic              busy;
`ifdef SAMPLE_DMA_IRQ_EN
    logic              irq;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t               sb[$];
    logic [DW-1:0]     fq0[$];
    logic [DW-1:0]     fq1[$];
    logic [CH-1:0]     push_en;
    logic [CH*DW-1:0]  push_dat;
    int                vectors = 0;
    int                errors  = 0;
    int                wr_cnt  = 0;
    int                rd_cnt  = 0;
    logic              hold_chk = 1'b0;
    logic [AW-1:0]     hold_a;
    logic [DW-1:0]     hold_d;
    logic [CH-1:0]     prev_rd = '0;

    always #5 clk = ~clk;

    sample_dma #(.CHANNELS(CH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .fifo_rd        (fifo_rd),
        .awaddr         (awaddr),
        .wdata          (wdata),
        .wvalid         (wvalid),
        .wready         (wready),
        .ctrl_addr      (ctrl_addr),
        .ctrl_wr_data   (ctrl_wr_data),
        .ctrl_wr_strobe (ctrl_wr_strobe),
        .ctrl_rd_data   (ctrl_rd_data),
`ifdef SAMPLE_DMA_IRQ_EN
        .irq            (irq),
`endif
        .busy           (busy)
    );

    // FIFO model: dout updates one clock after the read pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq0.delete();
            fq1.delete();
            fifo_empty <= '1;
            fifo_data  <= '0;
        end else begin
            if (fifo_rd[0] && fq0.size() > 0) fifo_data[15:0] <= fq0.pop_front();
            if (fifo_rd[1] && fq1.size() > 0) fifo_data[31:16] <= fq1.pop_front();
            if (push_en[0]) fq0.push_back(push_dat[15:0]);
            if (push_en[1]) fq1.push_back(push_dat[31:16]);
            fifo_empty <= {fq1.size() == 0, fq0.size() == 0};
        end
    end

    // Monitor on the falling edge: read pulses, hold stability, scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd != '0) begin
                rd_cnt += $countones(fifo_rd);
                vectors++;
                if ((fifo_rd & fifo_empty) != '0) begin
                    errors++;
                    $display("FAIL rd_empty: fifo_rd=%b empty=%b want no overlap", fifo_rd, fifo_empty);
                end
                vectors++;
                if ($countones(fifo_rd) > 1 || (fifo_rd & prev_rd) != '0) begin
                    errors++;
                    $display("FAIL rd_pulse: fifo_rd=%b prev=%b want single 1-cycle", fifo_rd, prev_rd);
                end
            end
            if (hold_chk && wvalid) begin
                vectors++;
                if (awaddr !== hold_a || wdata !== hold_d) begin
                    errors++;
                    $display("FAIL hold: got %h/%h want %h/%h", awaddr, wdata, hold_a, hold_d);
                end
            end
            hold_chk = wvalid && !wready;
            hold_a   = awaddr;
            hold_d   = wdata;
            if (wvalid && wready) begin
                wr_t e;
                wr_cnt++;
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h/%h want none", awaddr, wdata);
                end else begin
                    e = sb.pop_front();
                    if (awaddr !== e.a || wdata !== e.d) begin
                        errors++;
                        $display("FAIL write: got %h/%h want %h/%h", awaddr, wdata, e.a, e.d);
                    end
                end
            end
            prev_rd = fifo_rd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input int ch, input int r, input logic [31:0] v);
        ctrl_addr      = {4'(ch), 2'(r)};
        ctrl_wr_data   = v;
        ctrl_wr_strobe = 1'b1;
        step();
        ctrl_wr_strobe = 1'b0;
    endtask

    task automatic rd_reg(input int ch, input int r, output logic [31:0] v);
        ctrl_addr = {4'(ch), 2'(r)};
        #1;
        v = ctrl_rd_data;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] v);
        push_en[ch]            = 1'b1;
        push_dat[ch*DW +: DW]  = v;
        step();
        push_en = '0;
    endtask

    task automatic push2(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
        push_en  = 2'b11;
        push_dat = {v1, v0};
        step();
        push_en = '0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back('{a: a, d: d});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        step();
        step();
        rst    = 1'b0;
        wr_cnt = 0;
        rd_cnt = 0;
        step();
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wr_cnt < n && k < budget) begin
            step();
            k++;
        end
        vectors++;
        if (wr_cnt < n) begin
            errors++;
            $display("FAIL wr_timeout: got %0d writes want %0d", wr_cnt, n);
        end
        repeat (12) step();
        vectors++;
        if (wr_cnt != n) begin
            errors++;
            $display("FAIL wr_count: got %0d want %0d", wr_cnt, n);
        end
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic wait_wvalid(input int budget);
        int k = 0;
        while (!wvalid && k < budget) begin
            step();
            k++;
        end
        vectors++;
        if (!wvalid) begin
            errors++;
            $display("FAIL wvalid_timeout: got 0 want 1");
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        #2;
        vectors++;
        if ({fifo_rd, wvalid, busy} !== '0 || awaddr !== '0 || wdata !== '0) begin
            errors++;
            $display("FAIL reset_out: got rd=%b v=%b b=%b a=%h d=%h want 0",
                     fifo_rd, wvalid, busy, awaddr, wdata);
        end
        step();
        step();
        rst = 1'b0;
        step();
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_reg(c, r, v);
                vectors++;
                if (v !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_reg c%0d r%0d: got %h want 0", c, r, v);
                end
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        do_reset();
        wr_reg(1, 0, 32'hFFFF_FFFF);
        rd_reg(1, 0, v);
        vectors++;
        if (v !== (32'h3 | IRQEN)) begin
            errors++;
            $display("FAIL ctrl_bits: got %h want %h", v, 32'h3 | IRQEN);
        end
        wr_reg(1, 1, 32'hFFFF_FFFF);
        rd_reg(1, 1, v);
        vectors++;
        if (v !== 32'h00FF_FFFF) begin
            errors++;
            $display("FAIL base_bits: got %h want 00ffffff", v);
        end
        wr_reg(5, 1, 32'h1234);
        rd_reg(5, 1, v);
        vectors++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL bad_chan: got %h want 0", v);
        end
    endtask

    task automatic test_linear();
        logic [31:0] v;
        do_reset();
        wr_reg(0, 1, 32'h100);
        wr_reg(0, 2, 32'd4);
        wr_reg(0, 0, 32'h1);
        for (int i = 0; i < 4; i++) expect_wr(AW'(32'h100 + i), DW'(16'hA1 + i));
        for (int i = 0; i < 5; i++) push(0, DW'(16'hA1 + i));
        wait_writes(4, 200);
        rd_reg(0, 0, v);
        vectors++;
        if (v !== (32'h101 | HALF)) begin
            errors++;
            $display("FAIL lin_ctrl: got %h want %h", v, 32'h101 | HALF);
        end
        rd_reg(0, 3, v);
        vectors++;
        if (v !== 32'd3) begin
            errors++;
            $display("FAIL lin_wptr: got %h want 3", v);
        end
        vectors++;
        if (fq0.size() != 1 || rd_cnt != 4) begin
            errors++;
            $display("FAIL lin_left: got fifo=%0d rd=%0d want 1/4", fq0.size(), rd_cnt);
        end
    endtask

    task automatic test_circular();
        logic [31:0] v;
        do_reset();
        wr_reg(0, 1, 32'h100);
        wr_reg(0, 2, 32'd3);
        wr_reg(0, 0, 32'h3);
        for (int i = 0; i < 7; i++) expect_wr(AW'(32'h100 + (i % 3)), DW'(16'hC0 + i));
        for (int i = 0; i < 7; i++) push(0, DW'(16'hC0 + i));
        wait_writes(7, 300);
        rd_reg(0, 0, v);
        vectors++;
        if (v !== (32'h203 | HALF)) begin
            errors++;
            $display("FAIL circ_ctrl: got %h want %h", v, 32'h203 | HALF);
        end
        rd_reg(0, 3, v);
        vectors++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL circ_wptr: got %h want 1", v);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_reg(0, 1, 32'h100);
        wr_reg(0, 2, 32'd16);
        wr_reg(0, 0, 32'h1);
        wr_reg(1, 1, 32'h800);
        wr_reg(1, 2, 32'd16);
        wr_reg(1, 0, 32'h1);
        for (int k = 0; k < 4; k++) begin
            expect_wr(AW'(32'h100 + k), DW'(16'h1000 + k));
            expect_wr(AW'(32'h800 + k), DW'(16'h2000 + k));
        end
        for (int k = 0; k < 4; k++) push2(DW'(16'h1000 + k), DW'(16'h2000 + k));
        wait_writes(8, 300);
        vectors++;
        if (rd_cnt != 8) begin
            errors++;
            $display("FAIL b2b_rd: got %0d want 8", rd_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        wr_reg(0, 1, 32'h200);
        wr_reg(0, 2, 32'd8);
        wr_reg(0, 0, 32'h1);
        expect_wr(AW'(32'h200), DW'(16'h5A5A));
        expect_wr(AW'(32'h201), DW'(16'hA5A5));
        wready = 1'b0;
        push(0, 16'h5A5A);
        push(0, 16'hA5A5);
        wait_wvalid(50);
        repeat (10) step();
        vectors++;
        if (busy !== 1'b1 || rd_cnt != 1) begin
            errors++;
            $display("FAIL stall_state: got busy=%b rd=%0d want 1/1", busy, rd_cnt);
        end
        wready = 1'b1;
        wait_writes(2, 100);
        vectors++;
        if (rd_cnt != 2) begin
            errors++;
            $display("FAIL stall_rd: got %0d want 2", rd_cnt);
        end
    endtask

    task automatic test_wptr_race();
        logic [31:0] v;
        do_reset();
        wr_reg(0, 1, 32'h300);
        wr_reg(0, 2, 32'd1);
        wr_reg(0, 0, 32'h1);
        expect_wr(AW'(32'h300), DW'(16'h0055));
        wready = 1'b0;
        push(0, 16'h0055);
        wait_wvalid(50);
        wready         = 1'b1;
        ctrl_addr      = {4'd0, 2'd3};
        ctrl_wr_data   = 32'h0;
        ctrl_wr_strobe = 1'b1;
        step();
        ctrl_wr_strobe = 1'b0;
        rd_reg(0, 3, v);
        vectors++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL race_wptr: got %h want 0", v);
        end
        rd_reg(0, 0, v);
        vectors++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL race_ctrl: got %h want 1", v);
        end
        wait_writes(1, 20);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] v;
        do_reset();
        wr_reg(0, 1, 32'h400);
        wr_reg(0, 2, 32'd4);
        wr_reg(0, 0, 32'h3);
        wr_reg(1, 1, 32'h900);
        wready = 1'b0;
        push(0, 16'h7777);
        wait_wvalid(50);
        rst = 1'b1;
        #1;
        vectors++;
        if (wvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got wvalid=%b busy=%b want 0/0", wvalid, busy);
        end
        sb.delete();
        step();
        rst    = 1'b0;
        wready = 1'b1;
        step();
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_reg(c, r, v);
                vectors++;
                if (v !== 32'h0) begin
                    errors++;
                    $display("FAIL rst_reg c%0d r%0d: got %h want 0", c, r, v);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wready         = 1'b1;
        ctrl_addr      = '0;
        ctrl_wr_data   = '0;
        ctrl_wr_strobe = 1'b0;
        push_en        = '0;
        push_dat       = '0;
        test_reset();
        test_regs();
        test_linear();
        test_circular();
        test_back_to_back();
        test_stall();
        test_wptr_race();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
